dma_arbiter: RTL and testbench

- Round-robin request arbiter for the 4-channel AHB/APB DMA controller.
- Sits between the per-channel request logic and the shared bus master.
- Each cycle it picks at most one requesting channel and drives a registered one-hot grant.
- Fairness comes from a rotating priority pointer, so no requesting channel starves.

---
 rtl/dma_arbiter.sv | 85 ++++++++
 tb/tb_dma_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// rtl/dma_arbiter.sv - round-robin request arbiter for the DMA bus master
//
// Picks at most one requesting channel per clock and drives a registered
// one-hot grant. A last-granted pointer rotates priority so that every
// requesting channel is eventually served.
//
// Optional build macro: DMA_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest set req bit wins, no pointer
//   undefined -> round-robin (default)
//
// Ports:
//   clk    in   system clock, all state updates on the rising edge
//   rst_n  in   asynchronous active-low reset
//   req    in   [NUM_CHAN] per-channel request, bit i = channel i wants the bus
//   grant  out  [NUM_CHAN] registered one-hot grant, bit i = channel i owns the bus

module dma_arbiter #(
  parameter int NUM_CHAN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CHAN-1:0] req,
  output logic [NUM_CHAN-1:0] grant
);

  localparam int PTR_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  logic [NUM_CHAN-1:0] grant_q;
  logic [NUM_CHAN-1:0] grant_d;

  assign grant = grant_q;

`ifdef DMA_ARB_FIXED_PRIO_EN

  // Isolate the lowest set bit: req & (two's complement of req).
  always_comb begin
    grant_d = req & (~req + NUM_CHAN'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
    end else begin
      grant_q <= grant_d;
    end
  end

`else

  logic [PTR_W-1:0] last_q;
  logic [PTR_W-1:0] last_d;
  logic             found;
  int               idx;

  // Circular scan starting just after the last winner. The pointer only
  // moves when something is granted, so idle cycles keep fairness state.
  always_comb begin
    grant_d = '0;
    last_d  = last_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_CHAN; k++) begin
      idx = (int'(last_q) + k) % NUM_CHAN;
      if (!found && req[idx]) begin
        found        = 1'b1;
        grant_d[idx] = 1'b1;
        last_d       = PTR_W'(idx);
      end
    end
  end

  // Reset pointer to the top channel so channel 0 is scanned first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      last_q  <= PTR_W'(NUM_CHAN - 1);
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`endif

endmodule

// File: tb/tb_dma_arbiter.sv
// tb/tb_dma_arbiter.sv - self-checking bench for dma_arbiter

module tb_dma_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;

  int tests_run;
  int tests_failed;
  int model_last;

  dma_arbiter #(.NUM_CHAN(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: round-robin winner is the smallest requesting index above
  // the last winner, otherwise the smallest requesting index overall.
  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    for (int i = last + 1; i < N; i++) if (r[i]) return i;
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] r);
    logic [N-1:0] g;
    int w;
    g = '0;
`ifdef DMA_ARB_FIXED_PRIO_EN
    for (int i = N - 1; i >= 0; i--) if (r[i]) w = i;
    if (r != '0) g[w] = 1'b1;
`else
    w = rr_winner(r, model_last);
    if (w >= 0) begin
      g[w] = 1'b1;
      model_last = w;
    end
`endif
    return g;
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: grant=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply req before an edge, update the model, check after the edge.
  task automatic step(input logic [N-1:0] r, input string tag);
    logic [N-1:0] exp;
    req = r;
    @(posedge clk);
    exp = model_grant(r);
    @(negedge clk);
    check(tag, grant, exp);
    tests_run++;
    assert ($onehot0(grant) && ((grant & ~r) == '0)) else begin
      tests_failed++;
      $error("FAIL %s_inv: grant=%b req=%b expected onehot0 subset", tag, grant, r);
    end
  endtask

  task automatic step_exp(input logic [N-1:0] r, input logic [N-1:0] c, input string tag);
    step(r, tag);
    check({tag, "_plan"}, grant, c);
  endtask

  initial begin
    logic [N-1:0] r;
    tests_run    = 0;
    tests_failed = 0;
    model_last   = N - 1;
    rst_n        = 1'b0;
    req          = '0;

    // Reset held across edges
    @(posedge clk);
    @(negedge clk);
    check("reset_a", grant, 4'b0000);
    @(negedge clk);
    check("reset_b", grant, 4'b0000);
    rst_n = 1'b1;
    step_exp(4'b0000, 4'b0000, "post_reset_idle");

`ifdef DMA_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) step_exp(4'b1110, 4'b0010, "fixed_1110");
    step_exp(4'b1111, 4'b0001, "fixed_1111");
    step_exp(4'b1000, 4'b1000, "fixed_1000");
`else
    step_exp(4'b0001, 4'b0001, "single_a");
    step_exp(4'b0001, 4'b0001, "single_b");

    step_exp(4'b0011, 4'b0010, "two_a");
    step_exp(4'b0011, 4'b0001, "two_b");
    step_exp(4'b0011, 4'b0010, "two_c");
    step_exp(4'b0011, 4'b0001, "two_d");

    step_exp(4'b1111, 4'b0010, "all_a");
    step_exp(4'b1111, 4'b0100, "all_b");
    step_exp(4'b1111, 4'b1000, "all_c");
    step_exp(4'b1111, 4'b0001, "all_d");
    step_exp(4'b1111, 4'b0010, "all_e");
    step_exp(4'b1111, 4'b0100, "all_f");

    step_exp(4'b0000, 4'b0000, "idle_a");
    step_exp(4'b0000, 4'b0000, "idle_b");
    step_exp(4'b0000, 4'b0000, "idle_c");
    step_exp(4'b1111, 4'b1000, "resume");

    step_exp(4'b1111, 4'b0001, "pre_rst_a");
    step_exp(4'b1111, 4'b0010, "pre_rst_b");
    step_exp(4'b1111, 4'b0100, "pre_rst_c");
`endif

    // Asynchronous reset between edges
    rst_n = 1'b0;
    #1;
    check("async_rst", grant, 4'b0000);
    model_last = N - 1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step_exp(4'b1111, 4'b0001, "after_rst");

    // Randomized traffic with occasional mid-cycle resets
    for (int c = 0; c < 400; c++) begin
      r = N'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) r = '0;
      step(r, "rand");
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_rst", grant, 4'b0000);
        model_last = N - 1;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
